ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx_if.sv | 25 ++
 rtl/ps2_rx.sv | 156 +++++++++++++++
 tb/tb_ps2_rx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// Decoded key/status bundle from the PS/2 receiver to its consumer.
// Master drives the strobes and held key fields; there is no backpressure path.
interface ps2_rx_if;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_extended;
    logic       frame_err;

    modport master (
        output key_code,
        output key_valid,
        output key_release,
        output key_extended,
        output frame_err
    );

    modport slave (
        input key_code,
        input key_valid,
        input key_release,
        input key_extended,
        input frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host scan-code receiver; optional PS2_RX_PARITY_CHECK_EN rejects even-parity frames.
// Strobes fire one cycle after the filtered stop-bit edge; no backpressure, strobes are never held.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.master key
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tmo_cnt;
    logic          ext, brk;
    logic          frame_ok;
    logic          take, set_ext, set_brk, err;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt     <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign fall = filt & ~clk_s2 & (filt_cnt == FW'(FILTER_LEN - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst)
            par_bit <= 1'b0;
        else if (fall && state == PARITY)
            par_bit <= dat_s2;
    end

    assign frame_ok = dat_s2 & (^{shreg, par_bit});
`else
    assign frame_ok = dat_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        set_ext   = 1'b0;
        set_brk   = 1'b0;
        err       = 1'b0;
        // An edge in the same cycle restarts the timeout, so it takes priority.
        if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (!frame_ok)
                        err = 1'b1;
                    else if (shreg == 8'hE0)
                        set_ext = 1'b1;
                    else if (shreg == 8'hF0)
                        set_brk = 1'b1;
                    else
                        take = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt          <= 3'd0;
            shreg            <= 8'h00;
            tmo_cnt          <= '0;
            ext              <= 1'b0;
            brk              <= 1'b0;
            key.key_code     <= 8'h00;
            key.key_valid    <= 1'b0;
            key.key_release  <= 1'b0;
            key.key_extended <= 1'b0;
            key.frame_err    <= 1'b0;
        end else begin
            key.key_valid <= take;
            key.frame_err <= err;

            if (state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (fall && state == DATA) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == IDLE || fall)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (take) begin
                key.key_code     <= shreg;
                key.key_release  <= brk;
                key.key_extended <= ext;
            end

            if (set_ext) ext <= 1'b1;
            if (set_brk) brk <= 1'b1;
            if (take || err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed scan-code sequences plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_rx;
    localparam int FILT = 8;
    localparam int TMO  = 400;
`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_if kif();

    ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key      (kif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         rel;
        bit         ext;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         kv_count = 0;
    int         fe_count = 0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    logic [7:0] h_code = 8'h00;
    bit         h_rel = 1'b0;
    bit         h_ext = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int half);
        ps2_data = b;
        wait_cyc(half);
        ps2_clk = 1'b0;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    // Frame-level model: outcome of one complete frame from the protocol rules.
    task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        ev_t e;
        if (!stop_ok || (PCHK && !par_ok)) begin
            e = '{1'b1, 8'h00, 1'b0, 1'b0};
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e = '{1'b0, b, m_brk, m_ext};
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok = 1'b1,
                              input bit stop_ok = 1'b1, input int half = 40);
        bit p;
        p = par_ok ? ~(^b) : (^b);
        model_frame(b, par_ok, stop_ok);
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(b[i], half);
        send_bit(p, half);
        send_bit(stop_ok, half);
        ps2_data = 1'b1;
        wait_cyc(2 * half);
        check("pending_events", exp_q.size(), 0);
    endtask

    task automatic send_partial(input int nbits, input int half);
        ev_t e;
        e = '{1'b1, 8'h00, 1'b0, 1'b0};
        exp_q.push_back(e);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_bit(1'b0, half);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), half);
        ps2_data = 1'b1;
        wait_cyc(TMO + 2 * half + 40);
        check("timeout_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            check("strobe_overlap", kif.key_valid & kif.frame_err, 0);
            if (kif.key_valid || kif.frame_err) begin
                if (kif.key_valid) kv_count++;
                if (kif.frame_err) fe_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: key_valid=%0b frame_err=%0b, none expected at %0t",
                             kif.key_valid, kif.frame_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_err", kif.frame_err, e.is_err);
                    if (!e.is_err) begin
                        h_code = e.code;
                        h_rel  = e.rel;
                        h_ext  = e.ext;
                    end
                end
            end
            check("key_code", kif.key_code, h_code);
            check("key_release", kif.key_release, h_rel);
            check("key_extended", kif.key_extended, h_ext);
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv0, fe0, half, r;
        logic [7:0] b;

        wait_cyc(4);
        check("rst_key_code", kif.key_code, 8'h00);
        check("rst_key_valid", kif.key_valid, 0);
        check("rst_key_release", kif.key_release, 0);
        check("rst_key_extended", kif.key_extended, 0);
        check("rst_frame_err", kif.frame_err, 0);
        rst = 1'b0;
        wait_cyc(20);

        // Short low glitch with data low: must not be taken as a start bit.
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(5);
        ps2_clk  = 1'b1;
        wait_cyc(30);
        ps2_data = 1'b1;
        // Lone clock pulse with data high: start bit of 1 is ignored.
        send_bit(1'b1, 40);
        wait_cyc(40);

        send_frame(8'h1D);
        check("basic_kv_count", kv_count, 1);
        check("basic_code", kif.key_code, 8'h1D);
        check("basic_rel", kif.key_release, 0);
        check("basic_ext", kif.key_extended, 0);
        check("basic_fe_count", fe_count, 0);

        kv0 = kv_count;
        send_frame(8'hF0);
        check("brk_prefix_no_strobe", kv_count, kv0);
        send_frame(8'h1D);
        check("brk_code", kif.key_code, 8'h1D);
        check("brk_rel", kif.key_release, 1);
        check("brk_ext", kif.key_extended, 0);

        kv0 = kv_count;
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("ext_brk_single_kv", kv_count, kv0 + 1);
        check("ext_brk_code", kif.key_code, 8'h75);
        check("ext_brk_rel", kif.key_release, 1);
        check("ext_brk_ext", kif.key_extended, 1);
        send_frame(8'h29);
        check("after_ext_rel", kif.key_release, 0);
        check("after_ext_ext", kif.key_extended, 0);

        fe0 = fe_count;
        send_frame(8'h1D, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("bad_parity_code_held", kif.key_code, 8'h29);
        check("bad_parity_fe", fe_count, fe0 + 1);
`else
        check("bad_parity_accepted", kif.key_code, 8'h1D);
        check("bad_parity_no_fe", fe_count, fe0);
`endif

        send_frame(8'hE0);
        fe0 = fe_count;
        send_partial(4, 40);
        check("timeout_fe", fe_count, fe0 + 1);
        send_frame(8'h29);
        check("timeout_recover_code", kif.key_code, 8'h29);
        check("timeout_cleared_ext", kif.key_extended, 0);

        send_frame(8'hF0);
        fe0 = fe_count;
        send_frame(8'h33, 1'b1, 1'b0);
        check("stop_err_fe", fe_count, fe0 + 1);
        send_frame(8'h44);
        check("stop_err_cleared_rel", kif.key_release, 0);
        check("stop_err_code", kif.key_code, 8'h44);

        for (int i = 0; i < 24; i++) begin
            r    = $urandom_range(0, 9);
            half = $urandom_range(25, 60);
            b    = 8'($urandom_range(0, 255));
            case (r)
                0:       send_frame(8'hE0, 1'b1, 1'b1, half);
                1:       send_frame(8'hF0, 1'b1, 1'b1, half);
                2:       send_frame(b, 1'b1, 1'b0, half);
                3:       send_frame(b, 1'b0, 1'b1, half);
                4:       send_partial($urandom_range(0, 7), half);
                default: send_frame(b, 1'b1, 1'b1, half);
            endcase
        end

        // Reset in the high half of data bit 3 of a 0x1D frame after a break prefix.
        send_frame(8'hF0);
        b = 8'h1D;
        send_bit(1'b0, 40);
        for (int i = 0; i < 3; i++) send_bit(b[i], 40);
        ps2_data = b[3];
        wait_cyc(10);
        rst    = 1'b1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        h_code = 8'h00;
        h_rel  = 1'b0;
        h_ext  = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(2);
        check("midrst_code", kif.key_code, 8'h00);
        check("midrst_rel", kif.key_release, 0);
        check("midrst_ext", kif.key_extended, 0);
        check("midrst_kv", kif.key_valid, 0);
        check("midrst_fe", kif.frame_err, 0);
        kv0 = kv_count;
        fe0 = fe_count;
        wait_cyc(TMO + 100);
        ps2_data = 1'b1;
        check("midrst_no_kv", kv_count, kv0);
        check("midrst_no_fe", fe_count, fe0);
        send_frame(8'h1D);
        check("postrst_code", kif.key_code, 8'h1D);
        check("postrst_rel", kif.key_release, 0);

        wait_cyc(20);
        check("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
